// File: rtl/loop_issue_ctrl.sv
// loop_issue_ctrl: sequences a nested loop counter and offers one iteration per downstream handshake
package loop_issue_pkg;
    typedef struct packed {
        logic dval;
        logic inc;
        logic reset;
    } lp_ctl_t;
endpackage

module loop_issue_ctrl
    import loop_issue_pkg::*;
#(
    parameter int NDepth   = 3,
    parameter int IdxMaxDW = 11,
    parameter int CntDW    = 33
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cfg_val,
    output logic                o_cfg_rdy,
    input  logic [IdxMaxDW-1:0] i_cfg_size [NDepth],
    output logic [IdxMaxDW-1:0] o_loopSize [NDepth],
    output lp_ctl_t             o_ctl,
    input  logic [NDepth-1:0]   i_loopEnd,
    output logic                o_issue_val,
    input  logic                i_issue_rdy,
    output logic                o_last,
    input  logic                i_abort,
    output logic                o_done,
    output logic                o_err,
    output logic [CntDW-1:0]    o_issue_cnt
);
    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    // Counter reset also serves as the abort command so the loop counter never holds stale indices
    localparam lp_ctl_t CtlRst = '{dval: 1'b1, inc: 1'b0, reset: 1'b1};
    localparam lp_ctl_t CtlInc = '{dval: 1'b1, inc: 1'b1, reset: 1'b0};

    state_t               state_q, state_d;
    logic [IdxMaxDW-1:0]  size_q [NDepth];
    logic [IdxMaxDW-1:0]  size_d [NDepth];
    logic [CntDW-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 any_zero;

    // A zero trip count at any level makes the whole configuration meaningless
    always_comb begin
        any_zero = 1'b0;
        for (int l = 0; l < NDepth; l++) any_zero = any_zero | (i_cfg_size[l] == '0);
    end

    // Next-state and handshake decode; outputs depend only on state and live inputs
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        o_ctl       = '0;
        o_cfg_rdy   = state_q == IDLE;
        o_issue_val = state_q == RUN;
        o_last      = o_issue_val & (&i_loopEnd);
        o_done      = state_q == DONE;
        case (state_q)
            IDLE: begin
                if (i_cfg_val && any_zero) err_d = 1'b1;
                else if (i_cfg_val) begin
                    size_d  = i_cfg_size;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                o_ctl   = CtlRst;
                state_d = i_abort ? IDLE : RUN;
            end
            RUN: begin
                if (i_abort) begin
                    o_ctl   = CtlRst;
                    state_d = IDLE;
                end else if (i_issue_rdy) begin
                    o_ctl   = CtlInc;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = o_last ? DONE : RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int l = 0; l < NDepth; l++) size_q[l] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            size_q  <= size_d;
        end
    end

    assign o_loopSize  = size_q;
    assign o_issue_cnt = cnt_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_loop_issue_ctrl.sv
// tb_loop_issue_ctrl: directed checks of loop_issue_ctrl against a behavioural loop counter
module tb_loop_issue_ctrl;
    import loop_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_val = 1'b0;
    logic        cfg_rdy;
    logic [10:0] cfg_size [3] = '{11'd0, 11'd0, 11'd0};
    logic [10:0] loop_size [3];
    lp_ctl_t     ctl;
    logic [2:0]  loop_end;
    logic        issue_val;
    logic        rdy = 1'b0;
    logic        last;
    logic        abort = 1'b0;
    logic        done;
    logic        err;
    logic [32:0] cnt;
    logic [10:0] sz  [3] = '{11'd1, 11'd1, 11'd1};
    logic [10:0] idx [3] = '{11'd0, 11'd0, 11'd0};
    int          n_chk = 0;
    int          n_fail = 0;

    loop_issue_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_val(cfg_val), .o_cfg_rdy(cfg_rdy),
        .i_cfg_size(cfg_size), .o_loopSize(loop_size), .o_ctl(ctl),
        .i_loopEnd(loop_end), .o_issue_val(issue_val), .i_issue_rdy(rdy),
        .o_last(last), .i_abort(abort), .o_done(done), .o_err(err),
        .o_issue_cnt(cnt)
    );

    always #5 clk = ~clk;

    // Behavioural downstream loop counter: level 0 innermost, carry ripples outward
    always @(posedge clk) begin
        logic [10:0] nx [3];
        logic c;
        nx = idx;
        c = 1'b1;
        if (ctl.inc)
            for (int l = 0; l < 3; l++)
                if (c) begin
                    if (idx[l] == sz[l] - 11'd1) nx[l] = '0;
                    else begin
                        nx[l] = idx[l] + 11'd1;
                        c = 1'b0;
                    end
                end
        if (rst || ctl.reset) nx = '{11'd0, 11'd0, 11'd0};
        idx <= nx;
    end

    always_comb for (int l = 0; l < 3; l++) loop_end[l] = idx[l] == sz[l] - 11'd1;

    task automatic start_cfg(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c);
        @(negedge clk);
        cfg_val = 1'b1;
        cfg_size = '{a, b, c};
        sz = '{a, b, c};
        @(negedge clk);
        cfg_val = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        n_chk++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL rst_ctl got %b want 000", ctl); end
        n_chk++; if (issue_val !== 1'b0 || last !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_outs got val=%b last=%b done=%b want 0", issue_val, last, done); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++; if (cfg_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_cfg_rdy got %b want 1", cfg_rdy); end
        n_chk++; if (cnt !== 33'd0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_err got cnt=%0d err=%b want 0 0", cnt, err); end
        n_chk++; if (loop_size[0] !== 11'd0 || loop_size[1] !== 11'd0 || loop_size[2] !== 11'd0) begin n_fail++; $display("FAIL rst_size got %0d %0d %0d want 0 0 0", loop_size[0], loop_size[1], loop_size[2]); end
    endtask

    task automatic test_basic;
        rdy = 1'b1;
        start_cfg(11'd2, 11'd3, 11'd1);
        n_chk++; if (ctl !== 3'b101 || issue_val !== 1'b0) begin n_fail++; $display("FAIL basic_start got ctl=%b val=%b want 101 0", ctl, issue_val); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); #1;
            n_chk++; if (ctl !== 3'b110 || issue_val !== 1'b1) begin n_fail++; $display("FAIL basic_inc%0d got ctl=%b val=%b want 110 1", k, ctl, issue_val); end
            n_chk++; if (last !== (k == 6)) begin n_fail++; $display("FAIL basic_last%0d got %b want %b", k, last, k == 6); end
        end
        @(negedge clk); #1;
        n_chk++; if (done !== 1'b1 || ctl !== 3'b000 || issue_val !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%b ctl=%b val=%b want 1 000 0", done, ctl, issue_val); end
        @(negedge clk); #1;
        n_chk++; if (done !== 1'b0 || cfg_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_idle got done=%b rdy=%b want 0 1", done, cfg_rdy); end
        n_chk++; if (cnt !== 33'd6) begin n_fail++; $display("FAIL basic_cnt got %0d want 6", cnt); end
        n_chk++; if (loop_size[0] !== 11'd2 || loop_size[1] !== 11'd3 || loop_size[2] !== 11'd1) begin n_fail++; $display("FAIL basic_size got %0d %0d %0d want 2 3 1", loop_size[0], loop_size[1], loop_size[2]); end
    endtask

    task automatic test_ones;
        rdy = 1'b1;
        start_cfg(11'd1, 11'd1, 11'd1);
        n_chk++; if (ctl !== 3'b101) begin n_fail++; $display("FAIL ones_start got %b want 101", ctl); end
        @(negedge clk); #1;
        n_chk++; if (ctl !== 3'b110 || last !== 1'b1) begin n_fail++; $display("FAIL ones_hs got ctl=%b last=%b want 110 1", ctl, last); end
        @(negedge clk); #1;
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL ones_done got %b want 1", done); end
        @(negedge clk); #1;
        n_chk++; if (cnt !== 33'd1 || cfg_rdy !== 1'b1) begin n_fail++; $display("FAIL ones_end got cnt=%0d rdy=%b want 1 1", cnt, cfg_rdy); end
    endtask

    task automatic test_reject;
        @(negedge clk);
        cfg_val = 1'b1;
        cfg_size = '{11'd4, 11'd0, 11'd2};
        #1;
        n_chk++; if (ctl !== 3'b000) begin n_fail++; $display("FAIL rej_ctl0 got %b want 000", ctl); end
        @(negedge clk);
        cfg_val = 1'b0;
        #1;
        n_chk++; if (err !== 1'b1 || cfg_rdy !== 1'b1 || ctl !== 3'b000) begin n_fail++; $display("FAIL rej_state got err=%b rdy=%b ctl=%b want 1 1 000", err, cfg_rdy, ctl); end
        n_chk++; if (loop_size[0] !== 11'd1 || loop_size[1] !== 11'd1 || loop_size[2] !== 11'd1 || cnt !== 33'd1) begin n_fail++; $display("FAIL rej_hold got size %0d %0d %0d cnt=%0d want 1 1 1 cnt=1", loop_size[0], loop_size[1], loop_size[2], cnt); end
        rdy = 1'b1;
        start_cfg(11'd1, 11'd1, 11'd1);
        n_chk++; if (err !== 1'b0 || ctl !== 3'b101) begin n_fail++; $display("FAIL rej_clear got err=%b ctl=%b want 0 101", err, ctl); end
        @(negedge clk);
        @(negedge clk); #1;
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL rej_done got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        rdy = 1'b1;
        start_cfg(11'd4, 11'd2, 11'd2);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        n_chk++; if (ctl !== 3'b101 || issue_val !== 1'b1) begin n_fail++; $display("FAIL abort_ctl got ctl=%b val=%b want 101 1", ctl, issue_val); end
        @(negedge clk);
        abort = 1'b0;
        #1;
        n_chk++; if (cfg_rdy !== 1'b1 || issue_val !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_idle got rdy=%b val=%b done=%b want 1 0 0", cfg_rdy, issue_val, done); end
        n_chk++; if (cnt !== 33'd2) begin n_fail++; $display("FAIL abort_cnt got %0d want 2", cnt); end
        @(negedge clk); #1;
        n_chk++; if (done !== 1'b0 || ctl !== 3'b000) begin n_fail++; $display("FAIL abort_after got done=%b ctl=%b want 0 000", done, ctl); end
    endtask

    task automatic test_abort_ignored;
        rdy = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        cfg_val = 1'b1;
        cfg_size = '{11'd1, 11'd1, 11'd1};
        sz = '{11'd1, 11'd1, 11'd1};
        @(negedge clk);
        abort = 1'b0;
        cfg_val = 1'b0;
        #1;
        n_chk++; if (ctl !== 3'b101) begin n_fail++; $display("FAIL abidle_start got %b want 101", ctl); end
        @(negedge clk); #1;
        n_chk++; if (last !== 1'b1 || ctl !== 3'b110) begin n_fail++; $display("FAIL abidle_hs got last=%b ctl=%b want 1 110", last, ctl); end
        @(negedge clk);
        abort = 1'b1;
        #1;
        n_chk++; if (done !== 1'b1 || ctl !== 3'b000) begin n_fail++; $display("FAIL abdone got done=%b ctl=%b want 1 000", done, ctl); end
        @(negedge clk);
        abort = 1'b0;
        #1;
        n_chk++; if (cfg_rdy !== 1'b1 || cnt !== 33'd1) begin n_fail++; $display("FAIL abdone_end got rdy=%b cnt=%0d want 1 1", cfg_rdy, cnt); end
    endtask

    task automatic test_random;
        int hs = 0;
        logic seen_done = 1'b0;
        logic prev_stall = 1'b0;
        logic prev_last = 1'b0;
        rdy = 1'b0;
        start_cfg(11'd5, 11'd30, 11'd7);
        n_chk++; if (ctl !== 3'b101) begin n_fail++; $display("FAIL rnd_start got %b want 101", ctl); end
        for (int c = 0; c < 6000 && !seen_done; c++) begin
            @(negedge clk);
            rdy = 1'($urandom_range(0, 1));
            #1;
            if (done) seen_done = 1'b1;
            else begin
                n_chk++; if (issue_val !== 1'b1) begin n_fail++; $display("FAIL rnd_val hs=%0d got %b want 1", hs, issue_val); end
                n_chk++; if (last !== (hs == 1049)) begin n_fail++; $display("FAIL rnd_last hs=%0d got %b want %b", hs, last, hs == 1049); end
                if (prev_stall) begin
                    n_chk++; if (last !== prev_last) begin n_fail++; $display("FAIL rnd_stable hs=%0d got %b want %b", hs, last, prev_last); end
                end
                n_chk++; if (ctl !== (rdy ? 3'b110 : 3'b000)) begin n_fail++; $display("FAIL rnd_ctl hs=%0d got %b want %b", hs, ctl, rdy ? 3'b110 : 3'b000); end
                prev_stall = !rdy;
                prev_last = last;
                if (rdy) hs++;
            end
        end
        n_chk++; if (seen_done !== 1'b1) begin n_fail++; $display("FAIL rnd_timeout got done=%b want 1", seen_done); end
        n_chk++; if (hs != 1050 || cnt !== 33'd1050) begin n_fail++; $display("FAIL rnd_count got hs=%0d cnt=%0d want 1050 1050", hs, cnt); end
        rdy = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        rdy = 1'b1;
        start_cfg(11'd4, 11'd2, 11'd2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++; if (issue_val !== 1'b0 || done !== 1'b0 || cfg_rdy !== 1'b1) begin n_fail++; $display("FAIL rmid_outs got val=%b done=%b rdy=%b want 0 0 1", issue_val, done, cfg_rdy); end
        n_chk++; if (cnt !== 33'd0) begin n_fail++; $display("FAIL rmid_cnt got %0d want 0", cnt); end
        n_chk++; if (loop_size[0] !== 11'd0 || loop_size[1] !== 11'd0 || loop_size[2] !== 11'd0) begin n_fail++; $display("FAIL rmid_size got %0d %0d %0d want 0 0 0", loop_size[0], loop_size[1], loop_size[2]); end
        @(negedge clk); #1;
        n_chk++; if (done !== 1'b0 || issue_val !== 1'b0) begin n_fail++; $display("FAIL rmid_after got done=%b val=%b want 0 0", done, issue_val); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ones();
        test_reject();
        test_abort();
        test_abort_ignored();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/loop_issue_ctrl.md
LOOP_ISSUE_CTRL -- requirements
Module: loop_issue_ctrl

Interface
REQ-001 SHALL have parameter NDepth, default 3: number of nested loop levels driven into the downstream loop counter.
REQ-002 SHALL have parameter IdxMaxDW, default 11: width of each loop-size field.
REQ-003 SHALL have parameter CntDW, default 33: width of the issue counter; it SHALL equal NDepth*IdxMaxDW.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_cfg_val, input, 1 bit: configuration valid.
REQ-007 SHALL have port o_cfg_rdy, output, 1 bit: configuration ready; high only in IDLE.
REQ-008 SHALL have port i_cfg_size[NDepth], input, IdxMaxDW each: loop trip counts, level 0 innermost.
REQ-009 SHALL have port o_loopSize[NDepth], output, IdxMaxDW each: registered sizes driven to the loop counter.
REQ-010 SHALL have port o_ctl, output, LpCtl {dval, inc, reset}: control word to the loop counter.
REQ-011 SHALL have port i_loopEnd, input, NDepth bits: per-level end flags returned by the loop counter.
REQ-012 SHALL have port o_issue_val, output, 1 bit: an iteration is offered downstream.
REQ-013 SHALL have port i_issue_rdy, input, 1 bit: downstream accepts the iteration.
REQ-014 SHALL have port o_last, output, 1 bit: the offered iteration is the final one.
REQ-015 SHALL have port i_abort, input, 1 bit: cancel the current run.
REQ-016 SHALL have port o_done, output, 1 bit: one-cycle pulse when a run completes normally.
REQ-017 SHALL have port o_err, output, 1 bit: sticky flag set when a configuration is rejected.
REQ-018 SHALL have port o_issue_cnt, output, CntDW bits: number of iterations accepted in the current or last run.

Function
REQ-019 SHALL implement states IDLE, START, RUN, DONE.
REQ-020 In IDLE, a cycle with i_cfg_val&o_cfg_rdy SHALL accept the configuration.
REQ-021 An accepted configuration with any i_cfg_size level equal to 0 SHALL be rejected: set o_err, remain in IDLE, issue no o_ctl activity.
REQ-022 An accepted configuration with all levels nonzero SHALL register the sizes into o_loopSize, clear o_err, clear o_issue_cnt, and move to START.
REQ-023 START SHALL last one cycle with o_ctl={dval=1,inc=0,reset=1}, then move to RUN.
REQ-024 In RUN, o_issue_val SHALL be 1; o_last SHALL equal &i_loopEnd.
REQ-025 On each RUN cycle with o_issue_val&i_issue_rdy, the block SHALL drive o_ctl={1,1,0} and increment o_issue_cnt by 1.
REQ-026 When o_issue_val&i_issue_rdy occurs with o_last=1, the block SHALL move to DONE.
REQ-027 On RUN cycles without a handshake, o_ctl SHALL be all zeros; o_issue_val SHALL stay high and o_last SHALL stay stable (valid must not drop).
REQ-028 DONE SHALL last one cycle with o_done=1, then return to IDLE.
REQ-029 Total handshakes per run SHALL equal the product of the sizes; o_issue_cnt SHALL hold that value after DONE until the next accepted valid configuration.
REQ-030 i_abort in START or RUN SHALL take priority over a same-cycle handshake: drive o_ctl={1,0,1}, no count increment, go to IDLE, no o_done.
REQ-031 i_abort in IDLE or DONE SHALL be ignored.
REQ-032 o_loopSize SHALL change only on acceptance of a valid configuration.
REQ-033 o_ctl.dval SHALL equal o_ctl.inc|o_ctl.reset in every cycle.
REQ-034 o_ctl, o_issue_val, o_done and o_cfg_rdy SHALL be decoded combinationally from registered state and inputs, with zero added latency to the handshake.

Reset
REQ-035 While i_rst=1 at a rising edge, the block SHALL enter IDLE and set o_loopSize, o_issue_cnt and o_err to 0.
REQ-036 During and after reset: o_ctl=0, o_issue_val=0, o_last=0, o_done=0, and o_cfg_rdy=1 from the first cycle after reset.
REQ-037 i_rst asserted mid-RUN SHALL drop o_issue_val in the following cycle and produce no o_done.

Verification
REQ-038 Sizes {2,3,1} with i_issue_rdy=1 SHALL produce: START reset pulse, then 6 consecutive inc cycles, o_last only on the 6th, o_done one cycle later, o_issue_cnt=6.
REQ-039 Sizes {5,30,7} with random i_issue_rdy SHALL produce exactly 1050 handshakes, o_last only on the final one, and o_issue_val stable when ready is low.
REQ-040 Sizes {1,1,1} SHALL produce 1 handshake with o_last=1, then o_done.
REQ-041 Sizes {4,0,2} SHALL set o_err=1, produce no o_ctl activity, and keep o_cfg_rdy=1; a following valid configuration SHALL clear o_err.
REQ-042 i_abort asserted on the 3rd handshake cycle of sizes {4,2,2} SHALL produce o_ctl={1,0,1}, o_issue_cnt=2, return to IDLE, and no o_done.
REQ-043 i_rst asserted mid-run SHALL return the block to IDLE with o_issue_cnt=0 and o_loopSize=0.
